// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer: steps through the vehicle/pedestrian phase ring
// on timebase ticks, latches pedestrian calls, and handles emergency preemption
// with an all-red hold.
module traffic_phase_scheduler #(
  parameter int T_GREEN_A = 30,
  parameter int T_GREEN_B = 30,
  parameter int T_YELLOW  = 3,
  parameter int T_WALK    = 15,
  parameter int T_CLEAR   = 3,
  parameter int T_ALLRED  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [9:0] ped_req,
  input  logic       preempt,
  output logic [2:0] phase,
  output logic       phase_start,
  output logic [5:0] remaining,
  output logic [9:0] ped_pending,
  output logic       ped_served
);

  typedef enum logic [2:0] {
    GREEN_A   = 3'd0,
    YELLOW_A  = 3'd1,
    GREEN_B   = 3'd2,
    YELLOW_B  = 3'd3,
    PED_WALK  = 3'd4,
    PED_CLEAR = 3'd5,
    ALL_RED   = 3'd6
  } phase_e;

  phase_e     r_phase, w_phase_nxt;
  logic [5:0] r_count, w_count_nxt;
  logic [5:0] r_remaining, w_remaining_nxt;
  logic [9:0] r_ped_pending, w_ped_pending_nxt;
  logic       r_phase_start, r_ped_served;
  logic [5:0] w_len;
  logic       w_expire, w_preempt_tick, w_hold, w_change, w_enter_walk;

  // Length in ticks of each phase; the unused code 7 falls back to the all-red length.
  function automatic logic [5:0] phase_len(input phase_e p);
    case (p)
      GREEN_A:             phase_len = 6'(T_GREEN_A);
      GREEN_B:             phase_len = 6'(T_GREEN_B);
      YELLOW_A, YELLOW_B:  phase_len = 6'(T_YELLOW);
      PED_WALK:            phase_len = 6'(T_WALK);
      PED_CLEAR:           phase_len = 6'(T_CLEAR);
      default:             phase_len = 6'(T_ALLRED);
    endcase
  endfunction

  // Next phase, counter, remaining-time and pedestrian-latch computation.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_phase_nxt       = r_phase;
    w_hold            = 1'b0;
    w_count_nxt       = r_count;
    w_remaining_nxt   = r_remaining;
    w_len             = phase_len(r_phase);
    w_expire          = tick && (r_count == w_len - 6'd1);
    w_preempt_tick    = tick && preempt;

    case (r_phase)
      GREEN_A:   if (w_preempt_tick || w_expire) w_phase_nxt = YELLOW_A;
      GREEN_B:   if (w_preempt_tick || w_expire) w_phase_nxt = YELLOW_B;
      PED_WALK:  if (w_preempt_tick || w_expire) w_phase_nxt = PED_CLEAR;
      YELLOW_A: begin
        if (w_expire) begin
          if (preempt) begin
            w_phase_nxt = ALL_RED;
            w_hold      = 1'b1;
          end else begin
            w_phase_nxt = GREEN_B;
          end
        end
      end
      YELLOW_B: begin
        if (w_expire) begin
          if (preempt) begin
            w_phase_nxt = ALL_RED;
            w_hold      = 1'b1;
          end else if (|r_ped_pending) begin
            w_phase_nxt = PED_WALK;
          end else begin
            w_phase_nxt = GREEN_A;
          end
        end
      end
      PED_CLEAR: begin
        if (w_expire) begin
          if (preempt) begin
            w_phase_nxt = ALL_RED;
            w_hold      = 1'b1;
          end else begin
            w_phase_nxt = GREEN_A;
          end
        end
      end
      ALL_RED: begin
        // A preempt tick pins the countdown at zero; the first clear tick counts normally.
        if (w_preempt_tick)  w_hold      = 1'b1;
        else if (w_expire)   w_phase_nxt = GREEN_A;
      end
      default:               w_phase_nxt = ALL_RED;
    endcase

    w_change = (w_phase_nxt != r_phase);

    if (w_change) begin
      w_count_nxt     = 6'd0;
      w_remaining_nxt = w_hold ? 6'd0 : phase_len(w_phase_nxt);
    end else if (w_hold) begin
      w_count_nxt     = 6'd0;
      w_remaining_nxt = 6'd0;
    end else if (tick) begin
      w_count_nxt     = r_count + 6'd1;
      w_remaining_nxt = w_len - (r_count + 6'd1);
    end

    // Calls raised in the cycle the walk begins are treated as served by that walk.
    w_enter_walk = (w_phase_nxt == PED_WALK) && (r_phase != PED_WALK);
    if (w_enter_walk)            w_ped_pending_nxt = '0;
    else if (r_phase == PED_WALK) w_ped_pending_nxt = r_ped_pending;
    else                         w_ped_pending_nxt = r_ped_pending | ped_req;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= ALL_RED;
      r_count       <= 6'd0;
      r_remaining   <= 6'(T_ALLRED);
      r_ped_pending <= '0;
      r_phase_start <= 1'b0;
      r_ped_served  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values from
      // before this edge, independent of statement order.
      r_phase       <= w_phase_nxt;
      r_count       <= w_count_nxt;
      r_remaining   <= w_remaining_nxt;
      r_ped_pending <= w_ped_pending_nxt;
      r_phase_start <= w_change;
      r_ped_served  <= w_enter_walk;
    end
  end

  assign phase       = r_phase;
  assign phase_start = r_phase_start;
  assign remaining   = r_remaining;
  assign ped_pending = r_ped_pending;
  assign ped_served  = r_ped_served;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: the expected phase sequence is
// queued ahead of time and a monitor pops and checks each phase_start pulse
// (new phase, ticks spent in the previous phase, loaded remaining value).
module tb_traffic_phase_scheduler;

  localparam logic [2:0] GA = 3'd0, YA = 3'd1, GB = 3'd2, YB = 3'd3,
                         PW = 3'd4, PC = 3'd5, AR = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n, tick, preempt;
  logic [9:0] ped_req;
  logic [2:0] phase;
  logic       phase_start, ped_served;
  logic [5:0] remaining;
  logic [9:0] ped_pending;

  int total = 0;
  int bad   = 0;
  int tick_div = 1;
  int div_cnt  = 0;
  int mon_cnt  = 0;

  typedef struct {
    logic [2:0] ph;
    int         ticks;
    logic [5:0] rem;
  } exp_t;
  exp_t q[$];

  traffic_phase_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .ped_req     (ped_req),
    .preempt     (preempt),
    .phase       (phase),
    .phase_start (phase_start),
    .remaining   (remaining),
    .ped_pending (ped_pending),
    .ped_served  (ped_served)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [2:0] ph, input int ticks, input logic [5:0] rem);
    exp_t e;
    e.ph = ph; e.ticks = ticks; e.rem = rem;
    q.push_back(e);
  endfunction

  // Advance one clock; inputs change 1 ns after the edge, tick follows tick_div.
  task automatic step();
    @(posedge clk);
    #1;
    div_cnt = (div_cnt + 1 >= tick_div) ? 0 : div_cnt + 1;
    tick    = (div_cnt == 0);
  endtask

  task automatic wait_rem(input logic [2:0] p, input logic [5:0] r, input int budget, input string tag);
    int n = 0;
    while (!(phase === p && remaining === r) && n < budget) begin
      step();
      n++;
    end
    check(tag, {23'd0, phase, remaining}, {23'd0, p, r});
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  // Scoreboard side: count ticks per phase, compare each phase_start against the queue.
  always @(posedge clk) begin : monitor
    logic t, rs;
    exp_t e;
    t  = tick;
    rs = rst_n;
    #1;
    if (!rs || !rst_n) begin
      mon_cnt = 0;
    end else begin
      if (t) mon_cnt++;
      if (phase_start) begin
        check("start_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check($sformatf("phase_to_%0d", e.ph), phase, e.ph);
          check($sformatf("ticks_before_%0d", e.ph), mon_cnt, e.ticks);
          check($sformatf("remaining_at_%0d", e.ph), remaining, e.rem);
        end
        mon_cnt = 0;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; tick = 1'b0; preempt = 1'b0; ped_req = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_phase", phase, AR);
    check("rst_remaining", remaining, 6'd2);
    check("rst_pending", ped_pending, 10'h000);
    check("rst_phase_start", phase_start, 1'b0);
    check("rst_ped_served", ped_served, 1'b0);

    // 1: plain ring, no calls, tick every clock
    push(GA, 2, 30); push(YA, 30, 3); push(GB, 3, 30); push(YB, 30, 3); push(GA, 3, 30);
    tick  = 1'b1;
    rst_n = 1'b1;
    drain(200, "drain_ring");

    // 2 and 3: call on P5, call held through the walk, call raised in the clearance
    push(YA, 30, 3); push(GB, 3, 30); push(YB, 30, 3); push(PW, 3, 15); push(PC, 15, 3); push(GA, 3, 30);
    push(YA, 30, 3); push(GB, 3, 30); push(YB, 30, 3); push(PW, 3, 15); push(PC, 15, 3); push(GA, 3, 30);
    ped_req = 10'h010;
    step();
    ped_req = '0;
    check("pending_p5", ped_pending, 10'h010);
    wait_rem(YB, 1, 200, "wait_yb_end1");
    ped_req = 10'h001;
    step();
    check("walk1_phase", phase, PW);
    check("walk1_served", ped_served, 1'b1);
    check("walk1_pending", ped_pending, 10'h000);
    step();
    check("walk1_served_pulse", ped_served, 1'b0);
    wait_rem(PC, 3, 100, "wait_clear1");
    check("pending_after_walk", ped_pending, 10'h000);
    ped_req = 10'h002;
    step();
    ped_req = '0;
    check("pending_p2", ped_pending, 10'h002);
    wait_rem(YB, 1, 200, "wait_yb_end2");
    step();
    check("walk2_phase", phase, PW);
    check("walk2_served", ped_served, 1'b1);
    check("walk2_pending", ped_pending, 10'h000);
    drain(200, "drain_ped");

    // 4: preempt in GREEN_B at count 10, 20-tick hold, release
    push(YA, 30, 3); push(GB, 3, 30); push(YB, 11, 3); push(AR, 3, 0); push(GA, 22, 30);
    wait_rem(GB, 20, 200, "wait_gb_cnt10");
    preempt = 1'b1;
    step();
    check("preempt_yb_phase", phase, YB);
    repeat (3) step();
    check("preempt_ar_phase", phase, AR);
    check("preempt_ar_rem", remaining, 6'd0);
    repeat (20) step();
    check("hold_phase", phase, AR);
    check("hold_rem", remaining, 6'd0);
    preempt = 1'b0;
    step();
    check("release_rem", remaining, 6'd1);
    drain(20, "drain_preempt_gb");

    // 6: preempt in YELLOW_A at count 1 lets it finish; pending call survives
    push(YA, 30, 3); push(AR, 3, 0); push(GA, 6, 30);
    ped_req = 10'h080;
    step();
    ped_req = '0;
    wait_rem(YA, 2, 200, "wait_ya_cnt1");
    preempt = 1'b1;
    step();
    check("ya_completes", phase, YA);
    step();
    check("ya_then_ar", phase, AR);
    repeat (4) step();
    preempt = 1'b0;
    drain(20, "drain_preempt_ya");
    check("pending_kept", ped_pending, 10'h080);

    // 5: gapped tick scales durations, then reset in the middle of the walk
    push(YA, 30, 3); push(GB, 3, 30); push(YB, 30, 3); push(PW, 3, 15);
    tick_div = 5;
    wait_rem(YA, 3, 400, "wait_ya_5x");
    n = 0;
    do begin
      step();
      n++;
    end while (!phase_start && n < 100);
    check("ya_clocks_5x", n, 15);
    wait_rem(PW, 10, 1000, "wait_walk_5x");
    #3;
    rst_n = 1'b0;
    #1;
    check("midwalk_rst_phase", phase, AR);
    check("midwalk_rst_rem", remaining, 6'd2);
    check("midwalk_rst_pending", ped_pending, 10'h000);
    check("midwalk_rst_start", phase_start, 1'b0);
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
